// File: rtl/jtag_dbgreg_tx.sv
// jtag_dbgreg_tx: loads a SoC word through a valid/ready holding register and
// shifts it out LSB-first on JTDO1 (ER1) or JTDO2 (ER2), framed by a leading
// valid flag. JTAG pins are oversampled in the clk48m domain.
module jtag_dbgreg_tx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtck,
  input  logic             jshift,
  input  logic             jupdate,
  input  logic             jce1,
  input  logic             jce2,
  input  logic             jrstn,
  output logic             jtdo1,
  output logic             jtdo2,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_sel,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_done
);

  typedef enum logic {IDLE, ARMED} state_t;

  // Bit positions inside the synchroniser vectors.
  localparam int S_SHIFT = 0;
  localparam int S_UPD   = 1;
  localparam int S_CE1   = 2;
  localparam int S_CE2   = 3;
  localparam int S_RSTN  = 4;

  logic [3:0]     tck_s_q, tck_s_d;
  logic [4:0]     sync1_q, sync1_d;
  logic [4:0]     sync2_q, sync2_d;
  state_t         state_q, state_d;
  logic           chan_q, chan_d;
  logic [WIDTH:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic           hold_sel_q, hold_sel_d;
  logic           hold_full_q, hold_full_d;
  logic           tx_done_q, tx_done_d;
  logic           jtdo1_q, jtdo1_d;
  logic           jtdo2_q, jtdo2_d;

  logic tck_rise, tck_fall;
  logic s_shift, s_upd, s_ce1, s_ce2, s_rstn;
  logic consume;

  // TCK edge detection and two-flop synchronisation of the TAP control pins.
  always_comb begin
    tck_s_d  = {tck_s_q[2:0], jtck};
    sync1_d  = {jrstn, jce2, jce1, jupdate, jshift};
    sync2_d  = sync1_q;
    tck_rise = !tck_s_q[3] && tck_s_q[2];
    tck_fall = tck_s_q[3] && !tck_s_q[2];
    s_shift  = sync2_q[S_SHIFT];
    s_upd    = sync2_q[S_UPD];
    s_ce1    = sync2_q[S_CE1];
    s_ce2    = sync2_q[S_CE2];
    s_rstn   = sync2_q[S_RSTN];
  end

  // Frame FSM, shift register and holding register next-state logic.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    sr_d        = sr_q;
    hold_data_d = hold_data_q;
    hold_sel_d  = hold_sel_q;
    hold_full_d = hold_full_q;
    tx_done_d   = 1'b0;
    consume     = 1'b0;

    if (!s_rstn) begin
      // TAP reset aborts any frame but leaves a pending word in place.
      state_d = IDLE;
      sr_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tck_rise && (s_ce1 || s_ce2) && !s_shift) begin
            state_d = ARMED;
            chan_d  = s_ce2;
            if (hold_full_q && (hold_sel_q == s_ce2)) begin
              sr_d      = {hold_data_q, 1'b1};
              consume   = 1'b1;
              tx_done_d = 1'b1;
            end else begin
              sr_d = '0;
            end
          end
        end
        ARMED: begin
          // Zeros fill in from the top so over-long frames read zero.
          if (tck_fall && s_shift && (chan_q ? s_ce2 : s_ce1)) begin
            sr_d = {1'b0, sr_q[WIDTH:1]};
          end
          if (tck_rise && s_upd) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Capture looks at the pre-cycle holding state; a write into an empty
    // register in the same cycle simply waits for the next capture.
    if (consume) begin
      hold_full_d = 1'b0;
    end else if (tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_data_d = tx_data;
      hold_sel_d  = tx_sel;
    end

    // Outputs follow the next state so frame bit 0 appears with tx_done.
    jtdo1_d = (state_d == ARMED && !chan_d) ? sr_d[0] : 1'b0;
    jtdo2_d = (state_d == ARMED &&  chan_d) ? sr_d[0] : 1'b0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_s_q     <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      state_q     <= IDLE;
      chan_q      <= 1'b0;
      sr_q        <= '0;
      hold_data_q <= '0;
      hold_sel_q  <= 1'b0;
      hold_full_q <= 1'b0;
      tx_done_q   <= 1'b0;
      jtdo1_q     <= 1'b0;
      jtdo2_q     <= 1'b0;
    end else begin
      tck_s_q     <= tck_s_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      sr_q        <= sr_d;
      hold_data_q <= hold_data_d;
      hold_sel_q  <= hold_sel_d;
      hold_full_q <= hold_full_d;
      tx_done_q   <= tx_done_d;
      jtdo1_q     <= jtdo1_d;
      jtdo2_q     <= jtdo2_d;
    end
  end

  assign tx_ready = !hold_full_q;
  assign tx_done  = tx_done_q;
  assign jtdo1    = jtdo1_q;
  assign jtdo2    = jtdo2_q;

endmodule

// File: tb/tb_jtag_dbgreg_tx.sv
// Bench for jtag_dbgreg_tx: a TAP bus-functional model scans ER1/ER2 while a
// scoreboard queue of expected TDO bits is drained by an independent monitor.
module tb_jtag_dbgreg_tx;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  logic jtck, jshift, jupdate, jce1, jce2, jrstn;
  logic jtdo1, jtdo2;
  logic [WIDTH-1:0] tx_data;
  logic tx_sel, tx_valid, tx_ready, tx_done;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic exp_q[$];
  logic mon_en = 1'b0;
  logic mon_ch = 1'b0;

  jtag_dbgreg_tx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .jtck(jtck), .jshift(jshift), .jupdate(jupdate),
    .jce1(jce1), .jce2(jce2), .jrstn(jrstn), .jtdo1(jtdo1), .jtdo2(jtdo2),
    .tx_data(tx_data), .tx_sel(tx_sel), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the host samples TDO at each TCK falling pin edge of a shift
  // cycle, before the DUT has seen the edge.
  always @(negedge jtck) begin
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check(mon_ch ? "jtdo2_bit" : "jtdo1_bit", {31'd0, mon_ch ? jtdo2 : jtdo1}, {31'd0, e});
        check(mon_ch ? "jtdo1_idle" : "jtdo2_idle", {31'd0, mon_ch ? jtdo1 : jtdo2}, 32'd0);
      end
    end
  end

  // Counts every cycle tx_done is high, so a stretched pulse counts twice.
  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic flag, input logic [WIDTH-1:0] word, input int n);
    for (int k = 0; k < n; k++) begin
      if (k == 0)          exp_q.push_back(flag);
      else if (k <= WIDTH) exp_q.push_back(word[k-1]);
      else                 exp_q.push_back(1'b0);
    end
  endtask

  // One TCK period of 10 clk: controls change with the falling pin edge.
  task automatic tck_cyc(input logic c1, input logic c2, input logic sh, input logic up, input logic smp);
    @(negedge clk);
    jce1 = c1; jce2 = c2; jshift = sh; jupdate = up; mon_en = smp;
    jtck = 1'b0;
    repeat (5) @(negedge clk);
    jtck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan_begin(input logic ch);
    mon_ch = ch;
    tck_cyc(!ch, ch, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_n(input logic ch, input int n);
    for (int i = 0; i < n; i++) tck_cyc(!ch, ch, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic scan_end(input logic ch);
    tck_cyc(!ch, ch, 1'b0, 1'b1, 1'b0);
    tck_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic scan(input logic ch, input logic flag, input logic [WIDTH-1:0] word, input int n);
    push_frame(flag, word, n);
    scan_begin(ch);
    shift_n(ch, n);
    scan_end(ch);
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d, input logic sel);
    @(negedge clk);
    check("ready_before_write", {31'd0, tx_ready}, 32'd1);
    tx_data = d; tx_sel = sel; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ready_after_write", {31'd0, tx_ready}, 32'd0);
  endtask

  initial begin
    int d0;
    rst = 1'b1; jtck = 1'b0; jshift = 1'b0; jupdate = 1'b0; jce1 = 1'b0;
    jce2 = 1'b0; jrstn = 1'b1; tx_data = '0; tx_sel = 1'b0; tx_valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_jtdo1", {31'd0, jtdo1}, 32'd0);
    check("rst_jtdo2", {31'd0, jtdo2}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full word on ER1
    d0 = done_cnt;
    write_word(32'hDEADBEEF, 1'b0);
    scan(1'b0, 1'b1, 32'hDEADBEEF, 33);
    check("t2_done_count", done_cnt - d0, 32'd1);
    check("t2_ready", {31'd0, tx_ready}, 32'd1);

    // Empty capture, then a word for ER2 ignored by an ER1 scan
    d0 = done_cnt;
    scan(1'b0, 1'b0, 32'h0, 33);
    check("t3_empty_done", done_cnt - d0, 32'd0);
    write_word(32'h12345678, 1'b1);
    scan(1'b0, 1'b0, 32'h0, 33);
    check("t3_wrong_ch_done", done_cnt - d0, 32'd0);
    check("t3_still_held", {31'd0, tx_ready}, 32'd0);

    // Offer while full: must not overwrite the held word
    @(negedge clk);
    tx_data = 32'hAAAAAAAA; tx_sel = 1'b0; tx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_full_not_ready", {31'd0, tx_ready}, 32'd0);
    end
    tx_valid = 1'b0;
    scan(1'b1, 1'b1, 32'h12345678, 33);
    check("t4_er2_done", done_cnt - d0, 32'd1);
    check("t4_ready_after", {31'd0, tx_ready}, 32'd1);
    write_word(32'hAAAAAAAA, 1'b0);
    scan(1'b0, 1'b1, 32'hAAAAAAAA, 33);

    // Over-long frame reads zeros past the payload
    write_word(32'hFFFFFFFF, 1'b0);
    scan(1'b0, 1'b1, 32'hFFFFFFFF, 40);

    // TAP reset mid-shift
    write_word(32'h0F0F1234, 1'b0);
    push_frame(1'b1, 32'h0F0F1234, 10);
    scan_begin(1'b0);
    shift_n(1'b0, 10);
    @(negedge clk);
    mon_en = 1'b0; jrstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("trst_jtdo1", {31'd0, jtdo1}, 32'd0);
    jrstn = 1'b1;
    tck_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    write_word(32'h5A5A5A5A, 1'b1);
    scan(1'b1, 1'b1, 32'h5A5A5A5A, 33);

    // System reset mid-shift discards frame and held word
    write_word(32'h13579BDF, 1'b0);
    push_frame(1'b1, 32'h13579BDF, 5);
    scan_begin(1'b0);
    write_word(32'h2468ACE0, 1'b0);
    shift_n(1'b0, 5);
    @(negedge clk);
    check("pre_rst_jtdo1", {31'd0, jtdo1}, 32'd1);
    mon_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_jtdo1", {31'd0, jtdo1}, 32'd0);
    check("mid_rst_jtdo2", {31'd0, jtdo2}, 32'd0);
    check("mid_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("mid_rst_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    tck_cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    scan(1'b0, 1'b0, 32'h0, 33);
    check("post_rst_discard_done", done_cnt - d0, 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_dbgreg_tx.md
# jtag_dbgreg_tx

JTAG data-register transmitter that drives the JTAGG TDO inputs (JTDO1 for ER1/IR 0x32, JTDO2 for ER2/IR 0x38), completing the host-readable direction of the debug register path whose receive side already shifts TDI into dbgreg_in. The SoC loads a word through a valid/ready handshake. On the next Capture-DR of the matching ER, the block transfers the word into a shift register and presents it LSB-first on TDO. The block sits in the top level next to the JTAGG instance, clocked by clk48m, and samples TCK with the same oversampling scheme as the receive side.

## Interface
- WIDTH, 32, payload bits per word
- clk  in  1  system clock (clk48m); all logic is in this domain
- rst  in  1  synchronous, active-high reset
- jtck  in  1  JTAGG JTCK, asynchronous
- jshift  in  1  JTAGG JSHIFT, asynchronous
- jupdate  in  1  JTAGG JUPDATE, asynchronous
- jce1  in  1  JTAGG JCE1 (ER1 selected), asynchronous
- jce2  in  1  JTAGG JCE2 (ER2 selected), asynchronous
- jrstn  in  1  JTAGG JRSTN, active-low TAP reset, asynchronous
- jtdo1  out  1  to JTAGG JTDO1
- jtdo2  out  1  to JTAGG JTDO2
- tx_data  in  WIDTH  word to send
- tx_sel  in  1  target channel (0 = ER1, 1 = ER2)
- tx_valid  in  1  SoC offers a word
- tx_ready  out  1  holding register empty
- tx_done  out  1  one-cycle pulse when a valid word is captured into the shift register

## Operation
- Input synchronisation: jtck goes through a 4-bit shift chain tck_s[3:0], with tck_s[0] <= jtck. The rise event is tck_s[3]==0 && tck_s[2]==1. The fall event is tck_s[3]==1 && tck_s[2]==0. jshift, jupdate, jce1, jce2 and jrstn pass through 2-flop synchronisers. All J-signal decisions use the synchronised values.
- Holding register: hold_data[WIDTH-1:0], hold_sel, hold_full.
  - tx_ready = !hold_full.
  - A write is accepted when tx_valid && tx_ready. The write sets hold_full and latches tx_data and tx_sel.
  - hold_full clears only when a capture consumes the word.
- Shift register: sr[WIDTH:0]. Frame bit 0 is a valid flag; bits WIDTH:1 are the payload.
- State machine:
  - IDLE -> ARMED on a rise event when (jce1||jce2) && !jshift.
    - Set chan = jce2.
    - If hold_full && hold_sel==chan: load sr = {hold_data,1'b1}, clear hold_full, pulse tx_done.
    - Otherwise: load sr = 0, leave the holding register untouched, no tx_done.
  - ARMED: on a fall event with jshift && (chan ? jce2 : jce1), sr <= {1'b0, sr[WIDTH:1]}. Frames longer than WIDTH+1 bits read zeros.
  - ARMED -> IDLE on a rise event with jupdate.
  - A rise event with (jce1||jce2) && !jshift while in ARMED is ignored.
- Outputs:
  - jtdo1 = (state==ARMED && chan==0) ? sr[0] : 0.
  - jtdo2 = (state==ARMED && chan==1) ? sr[0] : 0.
  - Both are registered.
- TAP reset: synchronised jrstn low forces state to IDLE and sr to 0. The holding register is not affected.
- rst: state=IDLE, chan=0, sr=0, hold_full=0, hold_data=0, hold_sel=0, tck_s=0, all sync flops=0.
  - Output reset values: jtdo1=0, jtdo2=0, tx_ready=1, tx_done=0.
  - rst asserted mid-frame aborts the frame; a held word is discarded.

## Timing
- TCK must be at most clk/8, so each TCK phase lasts at least 4 clk cycles.
- Rise/fall event latency from the jtck pin edge is 3-4 clk cycles.
- Write accepted at cycle N: tx_ready=0 from cycle N+1.
- Capture event at cycle C: in cycle C+1, tx_done=1 for exactly one cycle, tx_ready=1, and jtdo shows frame bit 0.
- Fall event at cycle F: jtdo shows the next bit at F+1. The bit is stable before the following TCK rise.
- Write and capture in the same cycle: the capture sees the pre-cycle holding state. If the holding register was empty, the frame carries flag 0 and the new word waits for the next capture.
- Write and wrong-channel capture in the same cycle: no interaction.

## Test plan
- Reset: hold rst 3 cycles -> jtdo1=0, jtdo2=0, tx_ready=1, tx_done=0.
- Write 0xDEADBEEF with tx_sel=0, then a bus-functional TAP performs capture + 33 shifts on ER1 with TCK=clk/10 -> TDO bits are 1, then 0xDEADBEEF LSB-first; tx_done pulses once; tx_ready returns to 1; jtdo2 stays 0.
- Capture on ER1 with no word held -> 33 bits of 0, no tx_done. Then write 0x12345678 (sel=1) and scan ER1 -> flag 0 again, word still held; scan ER2 -> flag 1 + 0x12345678.
- While full, assert tx_valid with 0xAAAAAAAA -> not accepted. After capture, accept it; the next scan returns 0xAAAAAAAA.
- Scan 40 bits on ER1 after loading 0xFFFFFFFF -> bits 0..32 are 1, bits 33..39 are 0.
- Drop jrstn mid-shift after 10 bits -> jtdo1=0 and state IDLE within 3 cycles. A later word write/scan works normally. Asserting rst mid-shift -> all outputs return to their reset values the next cycle.
